// File: rtl/result_tx_sender_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : result_tx_sender_pkg
//  Purpose  : Shared definitions for the result transmit path: result and
//             index widths (common with the data feeder and result buffer),
//             frame delimiter bytes and the sender state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package result_tx_sender_pkg;

   // Result index width; 4 bits addresses up to 16 results
   localparam int TXS_IDX_W = 4;

   // One result word, always sent as two bytes
   localparam int TXS_RES_W = 16;

   // Frame delimiters
   localparam logic [7:0] TXS_HDR_BYTE = 8'hFE;
   localparam logic [7:0] TXS_TRL_BYTE = 8'hEF;

   // Sender states
   typedef enum logic [3:0] {
      S_IDLE = 4'd0,
      S_HDR  = 4'd1,
      S_CNT  = 4'd2,
      S_RD   = 4'd3,
      S_RDW  = 4'd4,
      S_HI   = 4'd5,
      S_LO   = 4'd6,
      S_TRL  = 4'd7,
      S_FIN  = 4'd8
   } txs_state_t;

endpackage : result_tx_sender_pkg
`default_nettype wire

// File: rtl/result_tx_sender.sv
`default_nettype none
// ============================================================================
//  Module   : result_tx_sender
//  Purpose  : Drains matrix-vector results from the result buffer and
//             streams them to the UART TX as a byte frame:
//             header, count (N), N x {result[15:8], result[7:0]}, trailer.
//  Revision : 1.0 - initial release
// ============================================================================
module result_tx_sender
   import result_tx_sender_pkg::*;
#(
   parameter int         RES_W    = TXS_RES_W,
   parameter int         IDX_W    = TXS_IDX_W,
   parameter logic [7:0] HDR_BYTE = TXS_HDR_BYTE,
   parameter logic [7:0] TRL_BYTE = TXS_TRL_BYTE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             start,
   input  logic [IDX_W-1:0] mat_size,
   output logic [IDX_W-1:0] res_addr,
   output logic             res_rd_en,
   input  logic [RES_W-1:0] res_data,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             done
);

   txs_state_t       r_state;
   logic [IDX_W-1:0] r_idx;
   logic [IDX_W-1:0] r_size;
   logic [7:0]       r_res_lo;
   logic [IDX_W-1:0] r_addr;
   logic             r_rd_en;
   logic [7:0]       r_tx_data;
   logic             r_tx_valid;
   logic             r_busy;
   logic             r_done;

   logic [IDX_W:0]   w_cnt;
   logic [7:0]       w_cnt_byte;
   logic             w_last;
   logic             w_xfer;
   logic [7:0]       w_next_byte;

   // Count byte is N = size + 1, computed one bit wider so size = all-ones
   // gives the full count rather than wrapping to zero
   assign w_cnt      = {1'b0, r_size} + (IDX_W+1)'(1);
   assign w_cnt_byte = 8'(w_cnt);
   assign w_last     = (r_idx == r_size);
   assign w_xfer     = r_tx_valid && tx_ready;

   // Byte to load into the output register when leaving the current state
   always_comb begin
      w_next_byte = 8'h00;
      case (r_state)
         S_IDLE:  w_next_byte = HDR_BYTE;
         S_HDR:   w_next_byte = w_cnt_byte;
         S_RDW:   w_next_byte = res_data[RES_W-1 -: 8];
         S_HI:    w_next_byte = r_res_lo;
         S_LO:    w_next_byte = TRL_BYTE;
         default: w_next_byte = 8'h00;
      endcase
   end

   // Frame sequencer with registered outputs; clear aborts to idle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_size     <= '0;
         r_res_lo   <= 8'h00;
         r_addr     <= '0;
         r_rd_en    <= 1'b0;
         r_tx_data  <= 8'h00;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else if (clear) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_addr     <= '0;
         r_rd_en    <= 1'b0;
         r_tx_valid <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         // Read strobe and done are single-cycle pulses
         r_rd_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_size     <= mat_size;
                  r_idx      <= '0;
                  r_tx_data  <= w_next_byte;
                  r_tx_valid <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_HDR;
               end
            end
            S_HDR: begin
               if (w_xfer) begin
                  r_tx_data <= w_next_byte;
                  r_state   <= S_CNT;
               end
            end
            S_CNT: begin
               if (w_xfer) begin
                  r_tx_valid <= 1'b0;
                  r_rd_en    <= 1'b1;
                  r_addr     <= r_idx;
                  r_state    <= S_RD;
               end
            end
            S_RD: begin
               r_state <= S_RDW;
            end
            S_RDW: begin
               // Buffer data is valid now; high byte goes straight out,
               // low byte is kept for the following beat
               r_res_lo   <= res_data[7:0];
               r_tx_data  <= w_next_byte;
               r_tx_valid <= 1'b1;
               r_state    <= S_HI;
            end
            S_HI: begin
               if (w_xfer) begin
                  r_tx_data <= w_next_byte;
                  r_state   <= S_LO;
               end
            end
            S_LO: begin
               if (w_xfer) begin
                  if (w_last) begin
                     r_tx_data <= w_next_byte;
                     r_state   <= S_TRL;
                  end else begin
                     r_tx_valid <= 1'b0;
                     r_idx      <= r_idx + IDX_W'(1);
                     r_addr     <= r_idx + IDX_W'(1);
                     r_rd_en    <= 1'b1;
                     r_state    <= S_RD;
                  end
               end
            end
            S_TRL: begin
               if (w_xfer) begin
                  r_tx_valid <= 1'b0;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_state    <= S_FIN;
               end
            end
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state    <= S_IDLE;
               r_tx_valid <= 1'b0;
               r_busy     <= 1'b0;
            end
         endcase
      end
   end

   assign res_addr  = r_addr;
   assign res_rd_en = r_rd_en;
   assign tx_data   = r_tx_data;
   assign tx_valid  = r_tx_valid;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule : result_tx_sender
`default_nettype wire

// File: tb/tb_result_tx_sender.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_tx_sender
//  Purpose  : Directed self-checking bench for result_tx_sender. Expected
//             frame bytes and read addresses are queued when a frame is
//             started and popped as the DUT transfers/reads.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_result_tx_sender;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        clear    = 1'b0;
   logic        start    = 1'b0;
   logic        tx_ready = 1'b0;
   logic [3:0]  mat_size = 4'h0;
   logic [3:0]  res_addr;
   logic        res_rd_en;
   logic [15:0] res_data;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        busy;
   logic        done;

   logic [15:0] mem [16];

   int checks    = 0;
   int failures  = 0;
   int cyc_n     = 0;
   int bytes_sent = 0;
   int done_cnt  = 0;
   int done_cyc  = 0;
   logic done_busy = 1'b0;
   logic p_stall = 1'b0;
   logic [7:0] p_data = 8'h00;

   logic [7:0] exp_q [$];
   int         addr_q [$];

   result_tx_sender dut (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .start     (start),
      .mat_size  (mat_size),
      .res_addr  (res_addr),
      .res_rd_en (res_rd_en),
      .res_data  (res_data),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Result buffer model: synchronous read, one cycle latency
   always @(posedge clk) begin
      if (res_rd_en) res_data <= mem[res_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle observation of the DUT at the falling edge
   task automatic monitor();
      if (p_stall && rst) begin
         chk("stall_valid", 32'(tx_valid), 32'd1);
         chk("stall_data", 32'(tx_data), 32'(p_data));
      end
      if (tx_valid && tx_ready) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL extra_byte observed=%0h expected=none", tx_data);
         end
         if (exp_q.size() != 0) chk("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
         bytes_sent++;
      end
      if (res_rd_en) begin
         checks++;
         assert (addr_q.size() != 0) else begin
            failures++;
            $error("FAIL extra_read observed=%0h expected=none", res_addr);
         end
         if (addr_q.size() != 0) chk("rd_addr", 32'(res_addr), 32'(addr_q.pop_front()));
      end
      if (done) begin
         done_cnt++;
         done_cyc  = cyc_n;
         done_busy = busy;
      end
      p_stall = tx_valid && !tx_ready && !clear && rst;
      p_data  = tx_data;
   endtask

   task automatic cyc();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic push_frame(input int n);
      exp_q.push_back(8'hFE);
      exp_q.push_back(8'(n));
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(mem[i][15:8]);
         exp_q.push_back(mem[i][7:0]);
         addr_q.push_back(i);
      end
      exp_q.push_back(8'hEF);
   endtask

   // One full frame; bp = random backpressure with a 5-cycle stall on the
   // first LO byte; disturb = extra start while busy and mat_size changed
   task automatic frame(input int n, input bit bp, input bit disturb);
      int k;
      int guard;
      int stall_left;
      bit stalled;
      push_frame(n);
      done_cnt   = 0;
      bytes_sent = 0;
      mat_size   = 4'(n - 1);
      start      = 1'b1;
      tx_ready   = 1'b1;
      k          = cyc_n;
      cyc();
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("hdr_valid_after_start", 32'(tx_valid), 32'd1);
      if (disturb) mat_size = ~mat_size;
      guard = 0; stall_left = 0; stalled = 0;
      while (done_cnt == 0 && guard < 2000) begin
         start = (disturb && guard == 3) ? 1'b1 : 1'b0;
         if (bp) begin
            if (!stalled && bytes_sent == 3 && tx_valid) begin
               stalled    = 1;
               stall_left = 5;
            end
            if (stall_left > 0) begin
               tx_ready = 1'b0;
               stall_left--;
            end else begin
               tx_ready = 1'($urandom_range(0, 1));
            end
         end
         cyc();
         guard++;
      end
      start    = 1'b0;
      tx_ready = 1'b1;
      chk("done_seen", 32'(done_cnt), 32'd1);
      chk("busy_low_at_done", 32'(done_busy), 32'd0);
      if (!bp && !disturb) chk("latency", 32'(done_cyc - k), 32'(4 * n + 4));
      cyc();
      cyc();
      chk("single_done", 32'(done_cnt), 32'd1);
      chk("bytes_left", 32'(exp_q.size()), 32'd0);
      chk("reads_left", 32'(addr_q.size()), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int guard;
      for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

      // Reset state
      rst = 1'b0;
      repeat (2) cyc();
      chk("rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_rd_en", 32'(res_rd_en), 32'd0);
      chk("rst_addr", 32'(res_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b1;
      cyc();

      // Single result
      mem[0] = 16'h1234;
      frame(1, 0, 0);

      // Three results
      mem[0] = 16'h0001; mem[1] = 16'hABCD; mem[2] = 16'hFFFF;
      frame(3, 0, 0);

      // Maximum size, count byte 0x10, last read at 15
      for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h0101);
      frame(16, 0, 0);

      // Backpressure
      frame(4, 1, 0);

      // Clear during the second result's HI byte
      mem[0] = 16'h1357; mem[1] = 16'h2468; mem[2] = 16'h9ABC;
      exp_q.push_back(8'hFE); exp_q.push_back(8'h03);
      exp_q.push_back(8'h13); exp_q.push_back(8'h57);
      addr_q.push_back(0); addr_q.push_back(1);
      done_cnt = 0; bytes_sent = 0;
      mat_size = 4'd2; start = 1'b1; tx_ready = 1'b1;
      cyc();
      start = 1'b0;
      guard = 0;
      while (!(bytes_sent == 4 && tx_valid) && guard < 200) begin
         cyc();
         guard++;
      end
      chk("clear_reach_hi", 32'(bytes_sent), 32'd4);
      tx_ready = 1'b0;
      clear    = 1'b1;
      start    = 1'b1;
      cyc();
      clear = 1'b0;
      start = 1'b0;
      chk("clear_tx_valid", 32'(tx_valid), 32'd0);
      chk("clear_busy", 32'(busy), 32'd0);
      chk("clear_done", 32'(done), 32'd0);
      chk("clear_rd_en", 32'(res_rd_en), 32'd0);
      chk("clear_addr", 32'(res_addr), 32'd0);
      tx_ready = 1'b1;
      repeat (20) cyc();
      chk("clear_no_done", 32'(done_cnt), 32'd0);
      chk("clear_no_bytes", 32'(exp_q.size()), 32'd0);
      chk("clear_no_reads", 32'(addr_q.size()), 32'd0);
      frame(3, 0, 0);

      // Extra start while busy and mat_size changed mid-frame
      for (int i = 0; i < 16; i++) mem[i] = 16'(16'hA000 + i * 16'h0111);
      frame(5, 0, 1);

      // Reset dropped mid-frame
      push_frame(4);
      mat_size = 4'd3; start = 1'b1; tx_ready = 1'b1;
      cyc();
      start = 1'b0;
      repeat (8) cyc();
      rst = 1'b0;
      #1;
      exp_q.delete();
      addr_q.delete();
      chk("mid_rst_tx_valid", 32'(tx_valid), 32'd0);
      chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
      chk("mid_rst_rd_en", 32'(res_rd_en), 32'd0);
      chk("mid_rst_addr", 32'(res_addr), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_done", 32'(done), 32'd0);
      repeat (2) cyc();
      rst = 1'b1;
      repeat (3) cyc();
      chk("post_rst_idle_valid", 32'(tx_valid), 32'd0);
      mem[0] = 16'h55AA; mem[1] = 16'h0F0F;
      frame(2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_result_tx_sender
`default_nettype wire
